// File: rtl/fir_stream_source.sv
// fir_stream_source: drives the FIR tile's pin-level input protocol.
// Runs coefficient load bursts, paces FIFO'd samples onto the filter at a
// programmable rate, and captures the filter result a fixed latency after
// each sample strobe.
module fir_stream_source #(
  parameter int NUM_TAPS   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 8,
  parameter int Y_LATENCY  = 2,
  localparam int CA_W      = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coef_wr,
  input  logic [CA_W-1:0]  coef_addr,
  input  logic [7:0]       coef_data,
  input  logic             load_start,
  input  logic [DIV_W-1:0] rate_div,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [7:0]       fir_x_n,
  output logic             fir_tvalid,
  output logic             fir_set_coeffs,
  input  logic [10:0]      fir_y_n,
  output logic             y_valid,
  output logic [10:0]      y_data,
  output logic             busy
);

  localparam int TAP_W = $clog2(NUM_TAPS + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [TAP_W-1:0] TAP_END  = TAP_W'(NUM_TAPS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [TAP_W-1:0]   r_tap, w_tap_nxt;
  logic               r_load_pend, w_load_pend_nxt;
  logic [DIV_W-1:0]   r_pace, w_pace_nxt;
  logic               w_emit_coef, w_emit_sample;
  logic [CA_W-1:0]    w_coef_idx;

  logic [7:0]         r_coef [NUM_TAPS];
  logic [7:0]         r_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic               w_push, w_empty, w_full;

  logic               r_s_ready, r_busy, r_tvalid, r_set;
  logic [7:0]         r_x_n;
  logic [Y_LATENCY-1:0] r_tag, w_tag_nxt;
  logic               r_y_valid;
  logic [10:0]        r_y_data;
  logic               w_sample_strobe;

  assign w_empty         = (r_count == '0);
  assign w_full          = (r_count == CNT_FULL);
  assign w_push          = s_valid && !w_full;
  // Only strobes that carried a sample (not a coefficient) get tagged.
  assign w_sample_strobe = r_tvalid && !r_set;

  // Sequencer decisions: next state, tap index, and what to put on the bus next cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_tap_nxt       = r_tap;
    w_load_pend_nxt = r_load_pend;
    w_emit_coef     = 1'b0;
    w_emit_sample   = 1'b0;
    w_coef_idx      = '0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_state_nxt = ST_LOAD;
          w_emit_coef = 1'b1;
          w_tap_nxt   = TAP_W'(1);
        end else begin
          w_tap_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (r_tap == TAP_END) begin
          w_state_nxt = ST_STREAM;
          w_tap_nxt   = '0;
        end else begin
          w_emit_coef = 1'b1;
          w_coef_idx  = r_tap[CA_W-1:0];
          w_tap_nxt   = r_tap + TAP_W'(1);
        end
      end
      ST_STREAM: begin
        // A load request lets this cycle's emission go out first, then takes over.
        if (r_load_pend) begin
          w_state_nxt     = ST_LOAD;
          w_emit_coef     = 1'b1;
          w_tap_nxt       = TAP_W'(1);
          w_load_pend_nxt = 1'b0;
        end else begin
          w_emit_sample   = !w_empty && (r_pace == '0);
          w_load_pend_nxt = load_start;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_tap_nxt       = '0;
        w_load_pend_nxt = 1'b0;
      end
    endcase
  end

  // Pace counter: reload on emission, count down otherwise, held at 0 outside STREAM.
  always_comb begin
    w_pace_nxt = '0;
    if (r_state != ST_STREAM) begin
      w_pace_nxt = '0;
    end else if (w_emit_sample) begin
      w_pace_nxt = rate_div;
    end else if (r_pace != '0) begin
      w_pace_nxt = r_pace - DIV_W'(1);
    end else begin
      w_pace_nxt = '0;
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_emit_sample) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_emit_sample) begin
      w_count_nxt = r_count - CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  generate
    if (Y_LATENCY > 1) begin : g_tag_shift
      assign w_tag_nxt = {r_tag[Y_LATENCY-2:0], w_sample_strobe};
    end else begin : g_tag_single
      assign w_tag_nxt = w_sample_strobe;
    end
  endgenerate

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tap       <= '0;
      r_load_pend <= 1'b0;
      r_pace      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tap       <= w_tap_nxt;
      r_load_pend <= w_load_pend_nxt;
      r_pace      <= w_pace_nxt;
    end
  end

  // Coefficient registers; frozen while a load burst is reading them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) r_coef[i] <= 8'h00;
    end else if (coef_wr && (r_state != ST_LOAD)) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  // Sample FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_s_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= s_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_emit_sample) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count   <= w_count_nxt;
      r_s_ready <= (w_count_nxt != CNT_FULL);
    end
  end

  // Filter-side bus: coefficient or sample strobe, x_n holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_n    <= 8'h00;
      r_tvalid <= 1'b0;
      r_set    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_LOAD);
      if (w_emit_coef) begin
        r_x_n    <= r_coef[w_coef_idx];
        r_tvalid <= 1'b1;
        r_set    <= 1'b1;
      end else if (w_emit_sample) begin
        r_x_n    <= r_mem[r_rd_ptr];
        r_tvalid <= 1'b1;
        r_set    <= 1'b0;
      end else begin
        r_tvalid <= 1'b0;
        r_set    <= 1'b0;
      end
    end
  end

  // Result capture: delay sample strobes, then latch fir_y_n when one emerges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag     <= '0;
      r_y_valid <= 1'b0;
      r_y_data  <= 11'h000;
    end else begin
      r_tag     <= w_tag_nxt;
      r_y_valid <= r_tag[Y_LATENCY-1];
      if (r_tag[Y_LATENCY-1]) begin
        r_y_data <= fir_y_n;
      end
    end
  end

  assign s_ready        = r_s_ready;
  assign fir_x_n        = r_x_n;
  assign fir_tvalid     = r_tvalid;
  assign fir_set_coeffs = r_set;
  assign y_valid        = r_y_valid;
  assign y_data         = r_y_data;
  assign busy           = r_busy;

endmodule

// File: tb/tb_fir_stream_source.sv
// Self-checking bench for fir_stream_source (default parameters).
// Reference model: expected sample order (queue of accepted samples),
// coefficient bursts against a model coefficient array, and result capture
// computed from a per-cycle log of sample strobes and driven fir_y_n.
module tb_fir_stream_source;

  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coef_wr;
  logic [1:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        load_start;
  logic [7:0]  rate_div;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [7:0]  fir_x_n;
  logic        fir_tvalid;
  logic        fir_set_coeffs;
  logic [10:0] fir_y_n;
  logic        y_valid;
  logic [10:0] y_data;
  logic        busy;

  fir_stream_source dut (
    .clk(clk), .rst_n(rst_n), .coef_wr(coef_wr), .coef_addr(coef_addr),
    .coef_data(coef_data), .load_start(load_start), .rate_div(rate_div),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .fir_x_n(fir_x_n),
    .fir_tvalid(fir_tvalid), .fir_set_coeffs(fir_set_coeffs), .fir_y_n(fir_y_n),
    .y_valid(y_valid), .y_data(y_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          bi = 0;
  int          n_samp = 0;
  int          n_coef = 0;
  logic [7:0]  exp_q[$];
  int          samp_cyc_q[$];
  logic [7:0]  m_coef[4];
  logic        samp_strobe[N];
  logic [10:0] ylog[N];
  logic [10:0] last_yd;

  function automatic logic [11:0] ix(input int c);
    return 12'(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  // Advance one cycle; check capture, sample order and coefficient bursts.
  task automatic tick();
    logic       acc;
    logic [7:0] d;
    logic       exp_yv;
    acc = s_valid && s_ready && rst_n;
    d   = s_data;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) exp_q.push_back(d);
    fir_y_n = ($urandom_range(0, 3) == 0) ? 11'h5A5 : 11'($urandom);
    ylog[ix(cyc)] = fir_y_n;
    exp_yv = (cyc >= 3) ? samp_strobe[ix(cyc - 3)] : 1'b0;
    chk("y_valid", 32'(y_valid), 32'(exp_yv));
    if (exp_yv) last_yd = ylog[ix(cyc - 1)];
    chk("y_data", 32'(y_data), 32'(last_yd));
    samp_strobe[ix(cyc)] = fir_tvalid && !fir_set_coeffs;
    if (fir_tvalid && !fir_set_coeffs) begin
      samp_cyc_q.push_back(cyc);
      n_samp++;
      if (exp_q.size() == 0) chk("sample_queued", 32'(exp_q.size() != 0), 32'd1);
      else chk("sample_order", 32'(fir_x_n), 32'(exp_q.pop_front()));
    end
    if (fir_tvalid && fir_set_coeffs) begin
      chk("coef_value", 32'(fir_x_n), 32'(m_coef[2'(bi)]));
      bi++;
      n_coef++;
    end else if (bi != 0) begin
      chk("burst_len", bi, 32'd4);
      bi = 0;
    end
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [7:0] d);
    coef_wr = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_wr = 1'b0;
    m_coef[a] = d;
  endtask

  initial begin
    int c0, base, nb, n_acc, guard;
    logic [7:0] xv;
    for (int i = 0; i < N; i++) begin samp_strobe[i] = 1'b0; ylog[i] = 11'h000; end
    for (int i = 0; i < 4; i++) m_coef[i] = 8'h00;
    last_yd = 11'h000;
    rst_n = 1'b0; coef_wr = 1'b0; coef_addr = 2'd0; coef_data = 8'h00;
    load_start = 1'b0; rate_div = 8'h00; s_valid = 1'b0; s_data = 8'h00;
    fir_y_n = 11'h000;

    // Reset state
    repeat (2) tick();
    chk("rst_tvalid", 32'(fir_tvalid), 32'd0);
    chk("rst_set", 32'(fir_set_coeffs), 32'd0);
    chk("rst_x_n", 32'(fir_x_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Coefficient load from IDLE
    for (int k = 0; k < 4; k++) wr_coef(2'(k), 8'(k + 1));
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("ld_tvalid", 32'(fir_tvalid), 32'd1);
      chk("ld_set", 32'(fir_set_coeffs), 32'd1);
      chk("ld_x_n", 32'(fir_x_n), 32'(k + 1));
      chk("ld_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("ld_end_set", 32'(fir_set_coeffs), 32'd0);
    chk("ld_end_busy", 32'(busy), 32'd0);

    // Paced samples, rate_div = 3
    rate_div = 8'd3;
    samp_cyc_q.delete();
    nb = n_coef;
    c0 = cyc;
    s_valid = 1'b1;
    s_data = 8'h10; tick();
    s_data = 8'h20; tick();
    s_data = 8'h30; tick();
    s_valid = 1'b0;
    repeat (12) tick();
    chk("pace_count", samp_cyc_q.size(), 32'd3);
    chk("pace_first", samp_cyc_q[0], c0 + 2);
    chk("pace_gap1", samp_cyc_q[1] - samp_cyc_q[0], 32'd4);
    chk("pace_gap2", samp_cyc_q[2] - samp_cyc_q[1], 32'd4);
    chk("pace_no_coef", n_coef - nb, 32'd0);

    // Backpressure: prime one emission so the pace counter is running, then fill
    rate_div = 8'hFF;
    base = n_samp;
    s_valid = 1'b1; s_data = 8'($urandom); tick();
    s_valid = 1'b0;
    repeat (3) tick();
    s_valid = 1'b1; s_data = 8'($urandom);
    n_acc = 0; guard = 0;
    while (s_ready && n_acc < 9 && guard < 20) begin
      tick();
      n_acc++; guard++;
      s_data = 8'($urandom);
    end
    chk("bp_accepted", n_acc, 32'd8);
    chk("bp_ready_low", 32'(s_ready), 32'd0);
    guard = 0;
    while (!s_ready && guard < 400) begin tick(); guard++; end
    chk("bp_ready_back", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    rate_div = 8'h00;
    repeat (300) tick();
    chk("bp_count", n_samp - base, 32'd10);
    chk("bp_drained", exp_q.size(), 32'd0);

    // Reload mid-stream with samples queued; coef write during burst ignored
    rate_div = 8'd2;
    nb = n_coef;
    s_valid = 1'b1;
    repeat (6) begin s_data = 8'($urandom); tick(); end
    s_valid = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    guard = 0;
    while (!busy && guard < 10) begin tick(); guard++; end
    chk("rl_busy", 32'(busy), 32'd1);
    coef_wr = 1'b1; coef_addr = 2'd3; coef_data = 8'hEE;
    tick();
    coef_wr = 1'b0;
    repeat (40) tick();
    chk("rl_coef_strobes", n_coef - nb, 32'd4);
    chk("rl_drained", exp_q.size(), 32'd0);

    // Randomized traffic with occasional reloads and rate changes
    for (int it = 0; it < 250; it++) begin
      s_valid = 1'($urandom);
      s_data  = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rate_div = 8'($urandom_range(0, 3));
      load_start = ($urandom_range(0, 39) == 0);
      tick();
    end
    s_valid = 1'b0;
    load_start = 1'b0;
    repeat (60) tick();
    chk("rand_drained", exp_q.size(), 32'd0);

    // Reset in the middle of a load burst
    rate_div = 8'hFF;
    s_valid = 1'b1;
    repeat (3) begin s_data = 8'($urandom); tick(); end
    s_valid = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    guard = 0;
    while (bi < 2 && guard < 20) begin tick(); guard++; end
    chk("mid_load_two", bi, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mr_tvalid", 32'(fir_tvalid), 32'd0);
    chk("mr_set", 32'(fir_set_coeffs), 32'd0);
    chk("mr_x_n", 32'(fir_x_n), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_s_ready", 32'(s_ready), 32'd1);
    chk("mr_y_valid", 32'(y_valid), 32'd0);
    exp_q.delete();
    bi = 0;
    last_yd = 11'h000;
    for (int i = 0; i < 4; i++) m_coef[i] = 8'h00;
    for (int i = 0; i < 8; i++) samp_strobe[ix(cyc - i)] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    xv = 8'($urandom);
    s_valid = 1'b1; s_data = xv; tick();
    s_valid = 1'b0;
    base = n_samp;
    repeat (5) tick();
    chk("idle_no_emit", n_samp - base, 32'd0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (12) tick();
    chk("post_rst_one_sample", n_samp - base, 32'd1);
    chk("post_rst_fifo_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_stream_source.md
# fir_stream_source

Host-side driver for the FIR filter tile's pin-level input protocol: 8-bit sample bus, `tvalid` strobe, `set_coeffs` flag. Loads a programmable coefficient set, then paces samples from a small FIFO onto the filter at a programmable rate. Captures the filter's 11-bit result a fixed number of cycles after each sample strobe. Sits in the test harness or a neighbouring tile, wired directly to the filter's `ui_in`, `uio_in[7:6]` and `uo_out`/`uio_out[2:0]`.

## Interface
- `NUM_TAPS`, default 4: coefficients per load sequence.
- `FIFO_DEPTH`, default 8: sample FIFO entries; power of two.
- `DIV_W`, default 8: width of the rate divider.
- `Y_LATENCY`, default 2: cycles from a sample `tvalid` cycle to the cycle in which `fir_y_n` holds that sample's result; ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `coef_wr` in 1: coefficient register write strobe.
- `coef_addr` in clog2(NUM_TAPS): coefficient index.
- `coef_data` in 8: coefficient value.
- `load_start` in 1: single-cycle request to run a load sequence.
- `rate_div` in DIV_W: sample spacing minus one.
- `s_valid` in 1: upstream sample valid.
- `s_data` in 8: upstream sample.
- `s_ready` out 1: `!fifo_full`.
- `fir_x_n` out 8: to filter `ui_in`.
- `fir_tvalid` out 1: to filter `uio_in[7]`.
- `fir_set_coeffs` out 1: to filter `uio_in[6]`.
- `fir_y_n` in 11: from filter `{uio_out[2:0], uo_out}`.
- `y_valid` out 1: captured-result strobe.
- `y_data` out 11: captured result.
- `busy` out 1: high while in LOAD.

## Operation
- Reset: state IDLE; FIFO empty; pace counter 0; delay line cleared. All outputs 0 except `s_ready`=1. Coefficient registers reset to 0.
- Coefficient registers: written on `coef_wr` in IDLE or STREAM; writes while `busy` are ignored.
- FSM states:
  - IDLE: no samples emitted. `load_start` → LOAD.
  - LOAD: emits coef[0]..coef[NUM_TAPS-1] in order, one per cycle. Each cycle drives `fir_tvalid`=1 and `fir_set_coeffs`=1. After the last coefficient → STREAM.
  - STREAM: emits samples. `load_start` → LOAD, applied after any emission already committed this cycle.
- `load_start` arriving while in LOAD is ignored.
- FIFO:
  - Push when `s_valid && s_ready`. Pushes continue in every state, including LOAD.
  - When full, `s_ready`=0 even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Emission in STREAM:
  - Fires in cycle c when FIFO non-empty and pace==0 and no load is pending.
  - Pops one entry. In c+1: `fir_tvalid`=1, `fir_x_n`=data, `fir_set_coeffs`=0.
  - Pace counter loads `rate_div` on emission and decrements to 0 otherwise.
  - Pace counter is forced to 0 on entry to STREAM.
- `fir_x_n` holds its last value when `fir_tvalid`=0.
- Capture:
  - A Y_LATENCY-deep delay line tracks sample strobes only; coefficient strobes are never tagged.
  - When a tagged strobe emerges, `y_data` is registered from `fir_y_n` and `y_valid` pulses for 1 cycle.
  - `y_data` holds its value between pulses.
- Reset mid-operation: immediate return to the reset state. Partial load sequence and FIFO contents are discarded.

## Timing
- `load_start` in IDLE at cycle t:
  - `fir_set_coeffs`=`fir_tvalid`=1 for cycles t+1..t+NUM_TAPS, with `fir_x_n`=coef[k] at t+1+k.
  - Cycle t+NUM_TAPS+1: `fir_set_coeffs`=0, state STREAM.
  - Earliest sample `fir_tvalid` is at t+NUM_TAPS+2.
- Push-to-emission latency from an empty FIFO in STREAM with pace==0: push at c, `fir_tvalid` at c+2.
- With the FIFO non-empty, consecutive sample strobes are spaced exactly `rate_div`+1 cycles. `rate_div`=0 gives back-to-back strobes.
- Sample `tvalid` at cycle s gives `y_valid` at s+Y_LATENCY+1, carrying `fir_y_n` sampled at s+Y_LATENCY.
- `rate_div` is sampled at each emission; changes take effect from the next reload.

## Test plan
- Reset, then write coef={0x01,0x02,0x03,0x04}, pulse `load_start` at t → `fir_x_n`=01,02,03,04 at t+1..t+4 with `tvalid`=`set_coeffs`=1; `busy` 1 for 4 cycles; `set_coeffs`=0 at t+5.
- After load, push 0x10,0x20,0x30 with `rate_div`=3 → `tvalid` pulses 4 cycles apart, `x_n`=10,20,30, `set_coeffs`=0 throughout.
- Push 9 samples back-to-back with `rate_div`=0xFF → `s_ready` drops after 8 accepted; 9th held until first pop; no sample lost or duplicated.
- Drive `fir_y_n`=0x5A5 at s+2 for a sample strobe at s (Y_LATENCY=2) → `y_valid` at s+3, `y_data`=0x5A5; no `y_valid` for any of the 4 coefficient strobes.
- `load_start` in STREAM with samples queued → emission pauses, 4-cycle coefficient burst, streaming resumes in original sample order; `coef_wr` during burst has no effect.
- Assert `rst_n`=0 mid-LOAD (after 2 coefficients) → outputs 0 immediately, `s_ready`=1, FIFO empty; state IDLE after release.
